// File: rtl/ysyx_23060208_ifu_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060208_ifu_fetch
//
// Instruction-fetch stage of the multi-cycle NPC core. It holds the PC and
// fetches exactly one instruction per retired instruction. Each fetch is a
// single-beat AXI4 read from instruction SRAM. The fetched {pc, inst} pair is
// offered to IDU with a valid/allowin handshake. The stage then waits for EXU
// to finish before it computes the next PC. Fetches never overlap.
//
// Ports
//   clock, reset        : clock; synchronous active-high reset
//   exu_to_ifu_bus      : {nextpc_taken, nextpc} from EXU
//   exu_to_ifu_valid    : EXU has completed; the bus is valid this cycle
//   isram_ar*           : AXI4 read-address channel (single beat, INCR, 4 B)
//   isram_r*            : AXI4 read-data channel; rlast/rid are ignored
//   ifu_to_idu_bus      : {pc, inst}; meaningful only while valid
//   ifu_to_idu_valid    : instruction available to IDU
//   idu_allowin         : IDU accepts the instruction this cycle
//   ifu_access_fault    : one-cycle pulse after an error read response
//   ifu_fetch_cnt       : number of completed R handshakes (wraps)
// ---------------------------------------------------------------------------
module ysyx_23060208_ifu_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [DATA_WIDTH:0]       exu_to_ifu_bus,
   input  logic                      exu_to_ifu_valid,
   output logic                      isram_arvalid,
   input  logic                      isram_arready,
   output logic [DATA_WIDTH-1:0]     isram_araddr,
   output logic [3:0]                isram_arid,
   output logic [7:0]                isram_arlen,
   output logic [2:0]                isram_arsize,
   output logic [1:0]                isram_arburst,
   input  logic                      isram_rvalid,
   output logic                      isram_rready,
   input  logic [2*DATA_WIDTH-1:0]   isram_rdata,
   input  logic [1:0]                isram_rresp,
   input  logic                      isram_rlast,
   input  logic [3:0]                isram_rid,
   output logic [2*DATA_WIDTH-1:0]   ifu_to_idu_bus,
   output logic                      ifu_to_idu_valid,
   input  logic                      idu_allowin,
   output logic                      ifu_access_fault,
   output logic [31:0]               ifu_fetch_cnt
);

   // An access fault delivers ebreak. The core then traps instead of
   // executing garbage data.
   localparam logic [DATA_WIDTH-1:0] EBREAK_INST = 32'h0010_0073;

   typedef enum logic [1:0] {
      FETCH_AR = 2'd0,
      FETCH_R  = 2'd1,
      SEND     = 2'd2,
      WAIT_EXU = 2'd3
   } state_e;

   state_e                  r_state;
   state_e                  w_nextState;
   logic [DATA_WIDTH-1:0]   r_pc;
   logic [DATA_WIDTH-1:0]   r_inst;
   logic [31:0]             r_fetchCnt;
   logic                    r_accessFault;

   logic                    w_rHandshake;
   logic                    w_exuFire;
   logic                    w_nextTaken;
   logic [DATA_WIDTH-1:0]   w_nextTarget;
   logic [DATA_WIDTH-1:0]   w_nextPc;
   logic [DATA_WIDTH-1:0]   w_selWord;
   logic                    w_unused;

   // rlast and rid carry no information for a single-beat, single-ID read.
   // Only bit 1 of rresp separates errors from OKAY/EXOKAY. The two low
   // bits of the EXU target are always forced to zero.
   assign w_unused = ^{isram_rlast, isram_rid, isram_rresp[0], exu_to_ifu_bus[1:0]};

   assign w_rHandshake = (r_state == FETCH_R) && isram_rvalid;
   assign w_exuFire    = (r_state == WAIT_EXU) && exu_to_ifu_valid;

   assign w_nextTaken  = exu_to_ifu_bus[DATA_WIDTH];
   assign w_nextTarget = {exu_to_ifu_bus[DATA_WIDTH-1:2], 2'b00};
   assign w_nextPc     = w_nextTaken ? w_nextTarget : r_pc + DATA_WIDTH'(4);

   // The SRAM returns a 64-bit doubleword. pc[2] selects which 32-bit half
   // holds the instruction.
   assign w_selWord = r_pc[2] ? isram_rdata[2*DATA_WIDTH-1:DATA_WIDTH]
                              : isram_rdata[DATA_WIDTH-1:0];

   // The state register and the fetch datapath registers. Events that arrive
   // outside the state that expects them are discarded by the handshake
   // qualifiers above. This is why stray rvalid or exu_to_ifu_valid pulses
   // cannot disturb pc, inst or the counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= FETCH_AR;
         r_pc          <= RESET_PC;
         r_inst        <= '0;
         r_fetchCnt    <= '0;
         r_accessFault <= 1'b0;
      end else begin
         r_state       <= w_nextState;
         r_accessFault <= w_rHandshake && isram_rresp[1];
         if (w_rHandshake) begin
            r_inst     <= isram_rresp[1] ? EBREAK_INST : w_selWord;
            r_fetchCnt <= r_fetchCnt + 32'd1;
         end
         if (w_exuFire) begin
            r_pc <= w_nextPc;
         end
      end
   end

   // Next-state logic and the Moore output decode. Each channel's
   // valid/ready depends only on the current state. The address and the IDU
   // bus therefore stay stable for as long as the state is held.
   always_comb begin
      w_nextState      = r_state;
      isram_arvalid    = 1'b0;
      isram_rready     = 1'b0;
      ifu_to_idu_valid = 1'b0;
      unique case (r_state)
         FETCH_AR: begin
            isram_arvalid = 1'b1;
            if (isram_arready) begin
               w_nextState = FETCH_R;
            end
         end
         FETCH_R: begin
            isram_rready = 1'b1;
            if (isram_rvalid) begin
               w_nextState = SEND;
            end
         end
         SEND: begin
            ifu_to_idu_valid = 1'b1;
            if (idu_allowin) begin
               w_nextState = WAIT_EXU;
            end
         end
         WAIT_EXU: begin
            if (exu_to_ifu_valid) begin
               w_nextState = FETCH_AR;
            end
         end
         default: begin
            w_nextState = FETCH_AR;
         end
      endcase
   end

   assign isram_araddr     = r_pc;
   assign isram_arid       = 4'd0;
   assign isram_arlen      = 8'd0;
   assign isram_arsize     = 3'b010;
   assign isram_arburst    = 2'b01;
   assign ifu_to_idu_bus   = {r_pc, r_inst};
   assign ifu_access_fault = r_accessFault;
   assign ifu_fetch_cnt    = r_fetchCnt;

endmodule

// File: tb/tb_ysyx_23060208_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060208_ifu_fetch
//
// Drives whole fetch/retire transactions into the IFU. Two sources supply
// them: a fixed table of vectors, and a randomized run. The randomized run
// takes its expected values from a transaction-level model of the PC and the
// instruction selection. Every transaction injects random noise on
// handshake inputs that the current state must ignore.
// ---------------------------------------------------------------------------
module tb_ysyx_23060208_ifu_fetch;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic        clock;
   logic        reset;
   logic [32:0] exu_to_ifu_bus;
   logic        exu_to_ifu_valid;
   logic        isram_arvalid;
   logic        isram_arready;
   logic [31:0] isram_araddr;
   logic [3:0]  isram_arid;
   logic [7:0]  isram_arlen;
   logic [2:0]  isram_arsize;
   logic [1:0]  isram_arburst;
   logic        isram_rvalid;
   logic        isram_rready;
   logic [63:0] isram_rdata;
   logic [1:0]  isram_rresp;
   logic        isram_rlast;
   logic [3:0]  isram_rid;
   logic [63:0] ifu_to_idu_bus;
   logic        ifu_to_idu_valid;
   logic        idu_allowin;
   logic        ifu_access_fault;
   logic [31:0] ifu_fetch_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] rdata;
      logic [1:0]  rresp;
      int          arDelay;
      int          rDelay;
      int          allowDelay;
      logic        taken;
      logic [31:0] nextpc;
      logic [31:0] expPc;
      logic [31:0] expInst;
      logic        expFault;
   } vec_t;

   vec_t vecs [7];

   ysyx_23060208_ifu_fetch dut (
      .clock            (clock),
      .reset            (reset),
      .exu_to_ifu_bus   (exu_to_ifu_bus),
      .exu_to_ifu_valid (exu_to_ifu_valid),
      .isram_arvalid    (isram_arvalid),
      .isram_arready    (isram_arready),
      .isram_araddr     (isram_araddr),
      .isram_arid       (isram_arid),
      .isram_arlen      (isram_arlen),
      .isram_arsize     (isram_arsize),
      .isram_arburst    (isram_arburst),
      .isram_rvalid     (isram_rvalid),
      .isram_rready     (isram_rready),
      .isram_rdata      (isram_rdata),
      .isram_rresp      (isram_rresp),
      .isram_rlast      (isram_rlast),
      .isram_rid        (isram_rid),
      .ifu_to_idu_bus   (ifu_to_idu_bus),
      .ifu_to_idu_valid (ifu_to_idu_valid),
      .idu_allowin      (idu_allowin),
      .ifu_access_fault (ifu_access_fault),
      .ifu_fetch_cnt    (ifu_fetch_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Fail and stop instead of hanging if the sequence ever stalls.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compares one observed value against the value the bench expects.
   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Advances one clock edge. Outputs are sampled 1 ns later, and the next
   // inputs are driven at the same point.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drives random values on every handshake input. Each caller overrides
   // the inputs that matter in the current phase. The others must be ignored.
   task automatic noise();
      exu_to_ifu_valid = 1'($urandom);
      exu_to_ifu_bus   = {1'($urandom), 32'($urandom)};
      isram_arready    = 1'($urandom);
      isram_rvalid     = 1'($urandom);
      isram_rdata      = {32'($urandom), 32'($urandom)};
      isram_rresp      = 2'($urandom_range(0, 3));
      isram_rlast      = 1'($urandom);
      isram_rid        = 4'($urandom);
      idu_allowin      = 1'($urandom);
   endtask

   // Runs one full fetch/retire transaction, starting from a state that is
   // about to issue the AR request. The transaction can be stopped while the
   // stage is waiting for EXU, so that reset can be exercised there.
   task automatic applyStimulus(input logic [63:0] rdata, input logic [1:0] rresp,
                                input int arDelay, input int rDelay,
                                input int allowDelay, input int waitDelay,
                                input logic taken, input logic [31:0] nextpc,
                                input logic stopAtWait,
                                input logic [31:0] expPc, input logic [31:0] expInst,
                                input logic expFault, input logic [31:0] expCnt);
      checkOutput("arid", 64'(isram_arid), 64'd0);
      checkOutput("arlen", 64'(isram_arlen), 64'd0);
      checkOutput("arsize", 64'(isram_arsize), 64'd2);
      checkOutput("arburst", 64'(isram_arburst), 64'd1);
      for (int i = 0; i <= arDelay; i++) begin
         checkOutput("arvalid_ar", 64'(isram_arvalid), 64'd1);
         checkOutput("araddr", 64'(isram_araddr), 64'(expPc));
         checkOutput("rready_ar", 64'(isram_rready), 64'd0);
         checkOutput("valid_ar", 64'(ifu_to_idu_valid), 64'd0);
         noise();
         isram_arready = (i == arDelay);
         step();
      end
      for (int i = 0; i <= rDelay; i++) begin
         checkOutput("arvalid_r", 64'(isram_arvalid), 64'd0);
         checkOutput("rready_r", 64'(isram_rready), 64'd1);
         checkOutput("valid_r", 64'(ifu_to_idu_valid), 64'd0);
         noise();
         isram_rvalid = (i == rDelay);
         if (i == rDelay) begin
            isram_rdata = rdata;
            isram_rresp = rresp;
         end
         step();
      end
      for (int i = 0; i <= allowDelay; i++) begin
         checkOutput("valid_send", 64'(ifu_to_idu_valid), 64'd1);
         checkOutput("rready_send", 64'(isram_rready), 64'd0);
         checkOutput("bus", ifu_to_idu_bus, {expPc, expInst});
         checkOutput("fetch_cnt", 64'(ifu_fetch_cnt), 64'(expCnt));
         checkOutput("fault", 64'(ifu_access_fault), (i == 0) ? 64'(expFault) : 64'd0);
         noise();
         idu_allowin = (i == allowDelay);
         step();
      end
      checkOutput("valid_drop", 64'(ifu_to_idu_valid), 64'd0);
      checkOutput("arvalid_wait", 64'(isram_arvalid), 64'd0);
      checkOutput("fault_end", 64'(ifu_access_fault), 64'd0);
      if (stopAtWait) begin
         exu_to_ifu_valid = 1'b0;
         return;
      end
      for (int i = 0; i <= waitDelay; i++) begin
         checkOutput("arvalid_wait_loop", 64'(isram_arvalid), 64'd0);
         checkOutput("valid_wait", 64'(ifu_to_idu_valid), 64'd0);
         noise();
         exu_to_ifu_valid = (i == waitDelay);
         if (i == waitDelay) begin
            exu_to_ifu_bus = {taken, nextpc};
         end
         step();
      end
      exu_to_ifu_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] modelPc;
      logic [31:0] modelCnt;
      logic [63:0] rd;
      logic [1:0]  rr;
      logic        tk;
      logic [31:0] np;
      logic [31:0] inst;

      vecs[0] = '{64'h11111111_00000413, 2'b00, 0, 0, 0, 1'b0, 32'h0,         32'h8000_0000, 32'h0000_0413, 1'b0};
      vecs[1] = '{64'hDEADBEEF_12345678, 2'b00, 5, 1, 3, 1'b1, 32'h8000_0103, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{64'hAAAAAAAA_00500093, 2'b11, 1, 2, 0, 1'b1, 32'h8000_0040, 32'h8000_0100, EBREAK,        1'b1};
      vecs[3] = '{64'h00000000_55555555, 2'b10, 0, 0, 2, 1'b0, 32'h1234_5678, 32'h8000_0040, EBREAK,        1'b1};
      vecs[4] = '{64'hCAFEF00D_0BADC0DE, 2'b01, 2, 0, 1, 1'b1, 32'hFFFF_FFFE, 32'h8000_0044, 32'hCAFE_F00D, 1'b0};
      vecs[5] = '{64'h13579BDF_02468ACE, 2'b00, 0, 3, 0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h1357_9BDF, 1'b0};
      vecs[6] = '{64'hFFFFFFFF_00000013, 2'b00, 1, 1, 1, 1'b1, 32'h8000_0041, 32'h0000_0000, 32'h0000_0013, 1'b0};

      reset            = 1'b1;
      exu_to_ifu_valid = 1'b0;
      exu_to_ifu_bus   = '0;
      isram_arready    = 1'b0;
      isram_rvalid     = 1'b0;
      isram_rdata      = '0;
      isram_rresp      = 2'b00;
      isram_rlast      = 1'b0;
      isram_rid        = 4'd0;
      idu_allowin      = 1'b0;
      repeat (2) step();

      checkOutput("reset_valid", 64'(ifu_to_idu_valid), 64'd0);
      checkOutput("reset_rready", 64'(isram_rready), 64'd0);
      checkOutput("reset_cnt", 64'(ifu_fetch_cnt), 64'd0);
      checkOutput("reset_fault", 64'(ifu_access_fault), 64'd0);
      checkOutput("reset_bus", ifu_to_idu_bus, {32'h8000_0000, 32'h0});
      reset = 1'b0;

      $display("[TB] table-driven vectors");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].rdata, vecs[i].rresp, vecs[i].arDelay, vecs[i].rDelay,
                       vecs[i].allowDelay, i % 3, vecs[i].taken, vecs[i].nextpc, 1'b0,
                       vecs[i].expPc, vecs[i].expInst, vecs[i].expFault, 32'(i + 1));
      end

      $display("[TB] reset while waiting for EXU");
      applyStimulus(64'h0000_0073_0000_0033, 2'b00, 0, 0, 0, 0, 1'b0, 32'h0, 1'b1,
                    32'h8000_0040, 32'h0000_0033, 1'b0, 32'd8);
      reset            = 1'b1;
      exu_to_ifu_valid = 1'b1;
      exu_to_ifu_bus   = {1'b1, 32'h1000_0000};
      step();
      checkOutput("midreset_pc", 64'(ifu_to_idu_bus[63:32]), 64'h8000_0000);
      checkOutput("midreset_valid", 64'(ifu_to_idu_valid), 64'd0);
      checkOutput("midreset_cnt", 64'(ifu_fetch_cnt), 64'd0);
      checkOutput("midreset_rready", 64'(isram_rready), 64'd0);
      reset            = 1'b0;
      exu_to_ifu_valid = 1'b0;
      isram_arready    = 1'b0;
      step();
      checkOutput("postreset_arvalid", 64'(isram_arvalid), 64'd1);
      checkOutput("postreset_araddr", 64'(isram_araddr), 64'h8000_0000);

      $display("[TB] randomized transactions against reference model");
      modelPc  = 32'h8000_0000;
      modelCnt = 32'd0;
      for (int n = 0; n < 40; n++) begin
         rd = {32'($urandom), 32'($urandom)};
         rr = 2'($urandom_range(0, 3));
         tk = 1'($urandom);
         np = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h8000_0000 + 32'($urandom_range(0, 255));
         if (rr[1]) begin
            inst = EBREAK;
         end else if ((modelPc % 8) == 4) begin
            inst = rd[63:32];
         end else begin
            inst = rd[31:0];
         end
         modelCnt = modelCnt + 1;
         applyStimulus(rd, rr, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), tk, np, 1'b0,
                       modelPc, inst, rr[1], modelCnt);
         modelPc = tk ? (np / 4) * 4 : modelPc + 4;
      end
      checkOutput("final_araddr", 64'(isram_araddr), 64'(modelPc));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
